// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg : debounce FSM state encoding and counter width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_pkg;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] PRESS_DB = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] REL_DB   = 2'd3;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for one asynchronous board input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic stage1_q, stage1_d;
   logic stage2_q, stage2_d;

   always_comb begin
      stage1_d = d;
      stage2_d = stage1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1_q <= RST_VAL;
         stage2_q <= RST_VAL;
      end else begin
         stage1_q <= stage1_d;
         stage2_q <= stage2_d;
      end
   end

   assign q = stage2_q;

endmodule

`default_nettype wire

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter : push-button debouncer with press/release pulses and held level.
// Optional auto-repeat of key_en while held: define KEY_AUTO_REPEAT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_filter
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int HOLD_CYC     = 50_000_000,
   parameter int REPEAT_CYC   = 10_000_000
) (
   input  logic s_clk,
   input  logic s_rst,
   input  logic key_in,
   output logic key_en,
   output logic key_sto,
   output logic key_rel
);

   localparam int CW = cnt_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

   logic          ks;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          en_q, en_d, sto_q, sto_d, rel_q, rel_d;
   logic          acc_pulse, rpt_pulse;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (s_clk),
      .rst (s_rst),
      .d   (key_in),
      .q   (ks)
   );

   // cnt holds the stable samples already seen; the entry sample counts as
   // the first, so acceptance lands DEBOUNCE_CYC+2 edges after the input edge
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sto_d     = sto_q;
      rel_d     = 1'b0;
      acc_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            if (!ks) begin
               if (DEBOUNCE_CYC <= 1) begin
                  state_d   = HELD;
                  acc_pulse = 1'b1;
                  sto_d     = 1'b1;
                  cnt_d     = '0;
               end else begin
                  state_d = PRESS_DB;
                  cnt_d   = CW'(1);
               end
            end
         end
         PRESS_DB: begin
            if (ks) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= DB_LAST) begin
               state_d   = HELD;
               acc_pulse = 1'b1;
               sto_d     = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (ks) begin
               if (DEBOUNCE_CYC <= 1) begin
                  state_d = IDLE;
                  rel_d   = 1'b1;
                  sto_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  state_d = REL_DB;
                  cnt_d   = CW'(1);
               end
            end
         end
         REL_DB: begin
            if (!ks) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q >= DB_LAST) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               sto_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sto_d   = 1'b0;
         end
      endcase
   end

`ifdef KEY_AUTO_REPEAT_EN
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

   logic [CW-1:0] rcnt_q, rcnt_d;
   logic          rep_q, rep_d;

   // rep_q selects the inter-repeat period once the first repeat has fired
   always_comb begin
      rcnt_d    = '0;
      rep_d     = 1'b0;
      rpt_pulse = 1'b0;
      if (state_q == HELD && !ks) begin
         rep_d = rep_q;
         if (rcnt_q >= (rep_q ? REP_LAST : HOLD_LAST)) begin
            rpt_pulse = 1'b1;
            rep_d     = 1'b1;
         end else begin
            rcnt_d = rcnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         rcnt_q <= '0;
         rep_q  <= 1'b0;
      end else begin
         rcnt_q <= rcnt_d;
         rep_q  <= rep_d;
      end
   end
`else
   assign rpt_pulse = 1'b0;
`endif

   assign en_d = acc_pulse | rpt_pulse;

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         en_q  <= 1'b0;
         sto_q <= 1'b0;
         rel_q <= 1'b0;
      end else begin
         en_q  <= en_d;
         sto_q <= sto_d;
         rel_q <= rel_d;
      end
   end

   assign key_en  = en_q;
   assign key_sto = sto_q;
   assign key_rel = rel_q;

endmodule

`default_nettype wire
